// File: rtl/mux_rr_feeder.sv
// Two-channel round-robin arbiter feeding a single registered output slot.
// The slot refills in the same cycle that it drains, so there are no bubbles.
module mux_rr_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             select,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   prio_q;
  logic   slot_free;
  logic   grant_a, grant_b;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    state_d   = state_q;
    slot_free = (state_q == EMPTY) || out_ready;

    // Qualifying with rst_n keeps both readies low while reset is held.
    if (rst_n && slot_free) begin
      if (a_valid && (!b_valid || !prio_q)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end

    if (grant_a || grant_b) begin
      state_d = FULL;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign out_valid = (state_q == FULL);

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      prio_q   <= 1'b0;
      select   <= 1'b0;
      out_data <= '0;
    end else begin
      state_q <= state_d;
      // The payload and select load only on a grant. They hold while EMPTY
      // or stalled, and prio turns away from the channel just served.
      if (grant_a || grant_b) begin
        out_data <= grant_b ? b_data : a_data;
        select   <= grant_b;
        prio_q   <= grant_a;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Directed self-checking bench for mux_rr_feeder.
// Expected values are hand-computed from the arbitration rules.
module tb_mux_rr_feeder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             a_valid, b_valid, out_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready, select, out_valid;
  logic [WIDTH-1:0] out_data;

  int n_checks = 0;
  int n_fails  = 0;

  mux_rr_feeder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .select    (select),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and
  // outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic exp_sel [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    a_data = 8'h11; b_data = 8'h22;
    #1;
    check("rst_a_ready",   a_ready,   0);
    check("rst_b_ready",   b_ready,   0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_select",    select,    0);

    // A single word from A: accepted at once, visible one cycle later.
    @(negedge clk);
    rst_n = 1'b1;
    b_valid = 1'b0;
    #1;
    check("a1_a_ready", a_ready, 1);
    check("a1_b_ready", b_ready, 0);
    tick();
    check("a1_out_valid", out_valid, 1);
    check("a1_out_data",  out_data,  8'h11);
    check("a1_select",    select,    0);

    // Drain with no new grant: the slot empties and the payload holds.
    a_valid = 1'b0;
    #1;
    check("drain_a_ready", a_ready, 0);
    tick();
    check("drain_out_valid", out_valid, 0);
    check("drain_out_data",  out_data,  8'h11);
    check("drain_select",    select,    0);

    // Only B valid: B is granted every cycle.
    b_valid = 1'b1; b_data = 8'h5B;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bonly_b_ready", b_ready, 1);
      check("bonly_a_ready", a_ready, 0);
      tick();
      check("bonly_out_valid", out_valid, 1);
      check("bonly_select",    select,    1);
      check("bonly_out_data",  out_data,  8'h5B);
    end

    // Both valid with the output draining: strict alternation starting at A.
    a_valid = 1'b1; a_data = 8'hA0; b_data = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_a_ready", a_ready, !exp_sel[i]);
      check("rr_b_ready", b_ready, exp_sel[i]);
      tick();
      check("rr_out_valid", out_valid, 1);
      check("rr_select",    select,    exp_sel[i]);
      check("rr_out_data",  out_data,  exp_sel[i] ? 8'hB0 : 8'hA0);
    end

    // Stall while holding B0: no grants, and everything holds.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_a_ready", a_ready, 0);
      check("stall_b_ready", b_ready, 0);
      tick();
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data",  out_data,  8'hB0);
      check("stall_select",    select,    1);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_a_ready", a_ready, 1);
    check("unstall_b_ready", b_ready, 0);
    tick();
    check("unstall_out_valid", out_valid, 1);
    check("unstall_out_data",  out_data,  8'hA0);
    check("unstall_select",    select,    0);

    // An asynchronous reset pulse between edges while FULL.
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data",  out_data,  0);
    check("arst_select",    select,    0);
    check("arst_a_ready",   a_ready,   0);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_a_ready", a_ready, 1);
    check("post_rst_b_ready", b_ready, 0);
    tick();
    check("post_rst_out_valid", out_valid, 1);
    check("post_rst_select",    select,    0);
    check("post_rst_out_data",  out_data,  8'hA0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mux_rr_feeder.md
MUX_RR_FEEDER -- requirements
Module: mux_rr_feeder

Interface
REQ-001 Parameter WIDTH, default 8, data width of each input channel and of the output word.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a_valid  input  1  channel A has a word on a_data.
REQ-005 a_data  input  WIDTH  channel A word.
REQ-006 a_ready  output  1  channel A word accepted this cycle when a_valid and a_ready are both high.
REQ-007 b_valid  input  1  channel B has a word on b_data.
REQ-008 b_data  input  WIDTH  channel B word.
REQ-009 b_ready  output  1  channel B word accepted this cycle when b_valid and b_ready are both high.
REQ-010 select  output  1  source of the word in out_data: 0 = A, 1 = B; drives the select of the downstream 2:1 mux.
REQ-011 out_valid  output  1  out_data/select hold a valid word.
REQ-012 out_data  output  WIDTH  registered word.
REQ-013 out_ready  input  1  downstream consumes the word when out_valid and out_ready are both high.

Function
REQ-014 The block SHALL be a 2-channel round-robin arbiter feeding a one-entry output register, with states EMPTY (out_valid=0) and FULL (out_valid=1), plus a priority bit prio (0 = A preferred, 1 = B preferred).
REQ-015 "Slot free" SHALL be defined as (state==EMPTY) or out_ready==1.
REQ-016 Grant SHALL be combinational: if slot free and only one channel valid, grant that channel; if both valid, grant A when prio=0, B when prio=1; if none valid or slot not free, no grant.
REQ-017 a_ready SHALL be high only when A is granted, b_ready only when B is granted; never both high in the same cycle.
REQ-018 On a grant, at the next edge out_data SHALL load the granted word, select SHALL load the granted channel index, state SHALL become FULL; latency from accept to out_valid = 1 cycle.
REQ-019 On a grant, prio SHALL be set to point away from the granted channel (grant A -> prio=1, grant B -> prio=0); with no grant prio SHALL hold.
REQ-020 FULL with out_ready=1 and no grant SHALL go to EMPTY at the next edge.
REQ-021 FULL with out_ready=1 and a grant (simultaneous drain and fill) SHALL stay FULL with the new word; out_valid SHALL remain high, no bubble.
REQ-022 FULL with out_ready=0 (stall): a_ready=b_ready=0; out_data, select, prio SHALL hold unchanged.
REQ-023 Sustained both-valid with out_ready=1 SHALL produce strictly alternating select values, one word per cycle.
REQ-024 While EMPTY, out_data and select SHALL hold their previous values; consumers SHALL qualify them with out_valid.
REQ-025 Input words not accepted SHALL NOT be modified or dropped by the block; inputs are expected to hold until accepted.

Reset
REQ-026 rst_n low SHALL asynchronously force state=EMPTY, out_valid=0, out_data=0, select=0, prio=0, independent of clk.
REQ-027 While rst_n is low, a_ready and b_ready SHALL be 0.
REQ-028 Reset asserted mid-transfer SHALL discard the held word; after deassertion the first both-valid grant SHALL go to A.

Verification
REQ-029 Reset release, a_valid=1 a_data=8'h11, b_valid=0, out_ready=1 -> a_ready=1; next cycle out_valid=1, out_data=8'h11, select=0.
REQ-030 Both valid (A=8'hA0, B=8'hB0, held), out_ready=1 for 4 cycles -> select sequence 0,1,0,1 starting one cycle after first accept; out_data A0,B0,A0,B0.
REQ-031 FULL with out_data=8'hB0, out_ready=0 for 3 cycles, both inputs valid -> a_ready=b_ready=0, out_data/select stable; on out_ready=1, A (prio=0) granted in same cycle, out_valid stays 1.
REQ-032 Only B valid for 3 cycles, out_ready=1 -> B granted every cycle, select=1 each; then both valid -> A granted first.
REQ-033 rst_n pulsed low between clock edges while FULL -> out_valid drops immediately without a clk edge; out_data=0, select=0; after release both-valid grants A.
